execute_stage: RTL and testbench

// Second CPU pipeline stage (EX). It sits between fetch/decode and MEM/WB.
// It consumes decoded opcode, operands and control bits, forwards hazards from
// its own EX/MEM register and from writeback, and computes ALU/address results.
// It holds the NVZ flag register returned to fetch/decode for branch evaluation.
// It runs an iterative multiplier and stalls the front end via oStall.

---
 rtl/execute_stage.sv | 217 +++++++++++++++++++++
 tb/tb_execute_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage: forwarded ALU/address datapath plus NVZ flags and a DW-cycle shift-add multiplier.
// Single-cycle ops register one edge after sampling; a MUL raises oStall for DW cycles and emits bubbles until it retires.
module execute_stage #(
  parameter int DW     = 16,
  parameter int FWD_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    iOpcode,
  input  logic [DW-1:0] iImm,
  input  logic [3:0]    iSr1,
  input  logic [3:0]    iSr2,
  input  logic [DW-1:0] iData1,
  input  logic [DW-1:0] iData2,
  input  logic          iAlutoReg,
  input  logic          iMemtoReg,
  input  logic          iBustoReg,
  input  logic          iALUSrc,
  input  logic          iMemRead,
  input  logic          iMemWrite,
  input  logic          iBusWrite,
  input  logic [3:0]    iWriteBackAddr,
  input  logic          iWbEn,
  input  logic [3:0]    iWbAddr,
  input  logic [DW-1:0] iWbData,
  output logic [DW-1:0] oResult,
  output logic [DW-1:0] oStoreData,
  output logic          oAlutoReg,
  output logic          oMemtoReg,
  output logic          oBustoReg,
  output logic          oMemRead,
  output logic          oMemWrite,
  output logic          oBusWrite,
  output logic [3:0]    oWriteBackAddr,
  output logic [2:0]    oNVZ,
  output logic          oStall
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_IMML = 5'b01000;
  localparam logic [4:0] OP_IMMH = 5'b01001;
  localparam logic [4:0] OP_LD   = 5'b01010;
  localparam logic [4:0] OP_ST   = 5'b01011;
  localparam logic [4:0] OP_DLD  = 5'b01100;
  localparam logic [4:0] OP_DST  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_SRA  = 5'b01111;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [DW-1:0]   r_result, r_store;
  logic [5:0]      r_ctrl;
  logic [3:0]      r_wba;
  logic [2:0]      r_nvz;
  logic [2*DW-1:0] r_acc, r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_mdest;

  logic [DW-1:0]   w_a, w_fwd_b, w_b, w_alu, w_add, w_sub;
  logic            w_flag_upd, w_v, w_mul_start;
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_result_nxt, w_store_nxt;
  logic [5:0]      w_ctrl_nxt;
  logic [3:0]      w_wba_nxt;
  logic [2:0]      w_nvz_nxt;

  // EX/MEM result wins over writeback; tag 0 is the hardwired zero register.
  function automatic logic [DW-1:0] f_fwd(input logic [3:0] tag, input logic [DW-1:0] dat,
                                          input logic exm_en, input logic [3:0] exm_addr,
                                          input logic [DW-1:0] exm_dat, input logic wb_en,
                                          input logic [3:0] wb_addr, input logic [DW-1:0] wb_dat);
    logic [DW-1:0] v;
    v = dat;
    if (FWD_EN != 0 && tag != 4'd0) begin
      if (exm_en && tag == exm_addr)     v = exm_dat;
      else if (wb_en && tag == wb_addr)  v = wb_dat;
    end
    return v;
  endfunction

  always_comb begin
    w_a     = f_fwd(iSr1, iData1, r_ctrl[5], r_wba, r_result, iWbEn, iWbAddr, iWbData);
    w_fwd_b = f_fwd(iSr2, iData2, r_ctrl[5], r_wba, r_result, iWbEn, iWbAddr, iWbData);
    w_b     = iALUSrc ? iImm : w_fwd_b;
    w_add   = w_a + w_b;
    w_sub   = w_a - w_b;
  end

  always_comb begin
    w_alu      = '0;
    w_flag_upd = 1'b0;
    w_v        = 1'b0;
    case (iOpcode)
      OP_ADD: begin
        w_alu      = w_add;
        w_flag_upd = 1'b1;
        w_v        = (w_a[DW-1] == w_b[DW-1]) && (w_add[DW-1] != w_a[DW-1]);
      end
      OP_SUB: begin
        w_alu      = w_sub;
        w_flag_upd = 1'b1;
        w_v        = (w_a[DW-1] != w_b[DW-1]) && (w_sub[DW-1] != w_a[DW-1]);
      end
      OP_AND: begin w_alu = w_a & w_b; w_flag_upd = 1'b1; end
      OP_OR:  begin w_alu = w_a | w_b; w_flag_upd = 1'b1; end
      OP_XOR: begin w_alu = w_a ^ w_b; w_flag_upd = 1'b1; end
      OP_SLL: begin w_alu = w_a << w_b[3:0]; w_flag_upd = 1'b1; end
      OP_SRA: begin w_alu = DW'($signed(w_a) >>> w_b[3:0]); w_flag_upd = 1'b1; end
      OP_IMML: w_alu = {w_a[DW-1:8], iImm[7:0]};
      OP_IMMH: w_alu[15:0] = {iImm[7:0], w_a[7:0]};
      OP_LD, OP_ST, OP_DLD, OP_DST: w_alu = w_add;
      default: w_alu = '0;
    endcase
  end

  assign w_prod = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mul_start  = 1'b0;
    w_result_nxt = '0;
    w_store_nxt  = '0;
    w_ctrl_nxt   = '0;
    w_wba_nxt    = '0;
    w_nvz_nxt    = r_nvz;
    case (r_state)
      S_IDLE: begin
        if (iOpcode == OP_MUL) begin
          w_state_nxt = S_BUSY;
          w_mul_start = 1'b1;
        end else begin
          w_result_nxt = w_alu;
          w_store_nxt  = w_fwd_b;
          w_ctrl_nxt   = {iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite};
          w_wba_nxt    = iWriteBackAddr;
          if (w_flag_upd) w_nvz_nxt = {w_alu[DW-1], w_v, (w_alu == '0)};
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt  = S_IDLE;
          w_result_nxt = w_prod[DW-1:0];
          w_ctrl_nxt   = 6'b100000;
          w_wba_nxt    = r_mdest;
          w_nvz_nxt    = {w_prod[DW-1], |w_prod[2*DW-1:DW], (w_prod[DW-1:0] == '0)};
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_store  <= '0;
      r_ctrl   <= '0;
      r_wba    <= '0;
      r_nvz    <= '0;
    end else begin
      r_result <= w_result_nxt;
      r_store  <= w_store_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_wba    <= w_wba_nxt;
      r_nvz    <= w_nvz_nxt;
    end
  end

  // Multiplicand shifts left while multiplier shifts right; one partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_mdest  <= '0;
    end else if (w_mul_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DW{1'b0}}, w_a};
      r_mplier <= w_b;
      r_cnt    <= CW'(DW);
      r_mdest  <= iWriteBackAddr;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  assign oResult        = r_result;
  assign oStoreData     = r_store;
  assign oAlutoReg      = r_ctrl[5];
  assign oMemtoReg      = r_ctrl[4];
  assign oBustoReg      = r_ctrl[3];
  assign oMemRead       = r_ctrl[2];
  assign oMemWrite      = r_ctrl[1];
  assign oBusWrite      = r_ctrl[0];
  assign oWriteBackAddr = r_wba;
  assign oNVZ           = r_nvz;
  assign oStall         = (r_state == S_BUSY);

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed corner cases then random ops against an arithmetic reference model.
module tb_execute_stage;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    iOpcode;
  logic [DW-1:0] iImm, iData1, iData2, iWbData;
  logic [3:0]    iSr1, iSr2, iWriteBackAddr, iWbAddr;
  logic          iAlutoReg, iMemtoReg, iBustoReg, iALUSrc, iMemRead, iMemWrite, iBusWrite, iWbEn;
  logic [DW-1:0] oResult, oStoreData;
  logic          oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite, oStall;
  logic [3:0]    oWriteBackAddr;
  logic [2:0]    oNVZ;

  execute_stage #(.DW(DW), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .iOpcode(iOpcode), .iImm(iImm), .iSr1(iSr1), .iSr2(iSr2),
    .iData1(iData1), .iData2(iData2), .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg),
    .iBustoReg(iBustoReg), .iALUSrc(iALUSrc), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iBusWrite(iBusWrite), .iWriteBackAddr(iWriteBackAddr), .iWbEn(iWbEn), .iWbAddr(iWbAddr),
    .iWbData(iWbData), .oResult(oResult), .oStoreData(oStoreData), .oAlutoReg(oAlutoReg),
    .oMemtoReg(oMemtoReg), .oBustoReg(oBustoReg), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oBusWrite(oBusWrite), .oWriteBackAddr(oWriteBackAddr), .oNVZ(oNVZ), .oStall(oStall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural view of the previous retirement, as seen by the next instruction.
  logic [3:0]  m_dest;
  logic        m_a2r;
  logic [15:0] m_res;
  logic [2:0]  m_nvz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] out_ctrl();
    return {oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    iOpcode = '0; iImm = '0; iSr1 = '0; iSr2 = '0; iData1 = '0; iData2 = '0;
    iAlutoReg = 0; iMemtoReg = 0; iBustoReg = 0; iALUSrc = 0; iMemRead = 0;
    iMemWrite = 0; iBusWrite = 0; iWriteBackAddr = '0; iWbEn = 0; iWbAddr = '0; iWbData = '0;
  endtask

  task automatic rand_inputs(input bit allow_mul);
    iOpcode = 5'($urandom_range(0, 31));
    if (!allow_mul && iOpcode == 5'd14) iOpcode = 5'd0;
    iImm = 16'($urandom); iData1 = 16'($urandom); iData2 = 16'($urandom); iWbData = 16'($urandom);
    iSr1 = 4'($urandom_range(0, 7)); iSr2 = 4'($urandom_range(0, 7));
    iWbAddr = 4'($urandom_range(0, 7)); iWriteBackAddr = 4'($urandom_range(0, 7));
    iWbEn = 1'($urandom); iALUSrc = 1'($urandom); iAlutoReg = 1'($urandom);
    iMemtoReg = 1'($urandom); iBustoReg = 1'($urandom); iMemRead = 1'($urandom);
    iMemWrite = 1'($urandom); iBusWrite = 1'($urandom);
  endtask

  task automatic model_fwd(input logic [3:0] tag, input logic [15:0] d, output logic [15:0] v);
    if (tag != 0 && m_a2r && tag == m_dest)        v = m_res;
    else if (tag != 0 && iWbEn && tag == iWbAddr)  v = iWbData;
    else                                           v = d;
  endtask

  task automatic run_single(input string tag);
    logic [15:0] a, fb, b, r;
    logic [5:0]  ectl;
    logic [3:0]  ewba;
    logic [2:0]  envz;
    int sa, sb, s;
    bit fl, v;
    model_fwd(iSr1, iData1, a);
    model_fwd(iSr2, iData2, fb);
    b  = iALUSrc ? iImm : fb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    fl = 0; v = 0; r = 0;
    case (iOpcode)
      5'd0:  begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); fl = 1; end
      5'd1:  begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); fl = 1; end
      5'd2:  begin r = a & b; fl = 1; end
      5'd3:  begin r = a | b; fl = 1; end
      5'd4:  begin r = a ^ b; fl = 1; end
      5'd6:  begin s = int'(a) * (2 ** int'(b[3:0])); r = s[15:0]; fl = 1; end
      5'd15: begin s = sa >>> b[3:0]; r = s[15:0]; fl = 1; end
      5'd8:  r = (a & 16'hFF00) | (iImm & 16'h00FF);
      5'd9:  r = {iImm[7:0], a[7:0]};
      5'd10, 5'd11, 5'd12, 5'd13: begin s = int'(a) + int'(b); r = s[15:0]; end
      default: r = 0;
    endcase
    ectl = {iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite};
    ewba = iWriteBackAddr;
    envz = fl ? {r[15], v, (r == 16'd0)} : m_nvz;
    tick();
    chk({tag, ".res"}, 32'(oResult), 32'(r));
    chk({tag, ".store"}, 32'(oStoreData), 32'(fb));
    chk({tag, ".ctrl"}, 32'(out_ctrl()), 32'(ectl));
    chk({tag, ".wba"}, 32'(oWriteBackAddr), 32'(ewba));
    chk({tag, ".nvz"}, 32'(oNVZ), 32'(envz));
    chk({tag, ".stall"}, 32'(oStall), 32'd0);
    m_res = r; m_a2r = ectl[5]; m_dest = ewba; m_nvz = envz;
  endtask

  task automatic run_mul(input string tag);
    logic [15:0] a, fb, b;
    logic [31:0] p;
    logic [3:0]  dest;
    int nstall;
    model_fwd(iSr1, iData1, a);
    model_fwd(iSr2, iData2, fb);
    b    = iALUSrc ? iImm : fb;
    p    = {16'd0, a} * {16'd0, b};
    dest = iWriteBackAddr;
    tick();
    chk({tag, ".stall0"}, 32'(oStall), 32'd1);
    chk({tag, ".bub_res0"}, 32'(oResult), 32'd0);
    chk({tag, ".bub_ctl0"}, 32'(out_ctrl()), 32'd0);
    chk({tag, ".bub_wba0"}, 32'(oWriteBackAddr), 32'd0);
    nstall = 1;
    for (int c = 0; c < 40 && oStall; c++) begin
      rand_inputs(1);
      tick();
      if (oStall) begin
        nstall++;
        chk({tag, ".bub_res"}, 32'(oResult), 32'd0);
        chk({tag, ".bub_ctl"}, 32'(out_ctrl()), 32'd0);
        chk({tag, ".bub_nvz"}, 32'(oNVZ), 32'(m_nvz));
      end
    end
    m_res = p[15:0]; m_a2r = 1; m_dest = dest;
    m_nvz = {p[15], (p[31:16] != 16'd0), (p[15:0] == 16'd0)};
    chk({tag, ".stall_cycles"}, 32'(nstall), 32'(DW));
    chk({tag, ".res"}, 32'(oResult), 32'(p[15:0]));
    chk({tag, ".ctrl"}, 32'(out_ctrl()), 32'b100000);
    chk({tag, ".wba"}, 32'(oWriteBackAddr), 32'(dest));
    chk({tag, ".nvz"}, 32'(oNVZ), 32'(m_nvz));
  endtask

  task automatic model_reset();
    m_dest = 0; m_a2r = 0; m_res = 0; m_nvz = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    tick(); tick();
    chk("rst.res", 32'(oResult), 32'd0);
    chk("rst.ctrl", 32'(out_ctrl()), 32'd0);
    chk("rst.nvz", 32'(oNVZ), 32'd0);
    chk("rst.stall", 32'(oStall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    iOpcode = 5'd0; iData1 = 16'h7FFF; iData2 = 16'h0001; iAlutoReg = 1; iWriteBackAddr = 4'd1;
    run_single("add_ovf");
    chk("add_ovf.lit_res", 32'(oResult), 32'h8000);
    chk("add_ovf.lit_nvz", 32'(oNVZ), 32'b110);

    iOpcode = 5'd1; iSr1 = 4'd1; iSr2 = 4'd1; iData1 = 16'h1111; iData2 = 16'h0222; iWriteBackAddr = 4'd2;
    run_single("sub_exm");
    chk("sub_exm.lit_res", 32'(oResult), 32'd0);
    chk("sub_exm.lit_nvz", 32'(oNVZ), 32'b001);

    clear_inputs(); iOpcode = 5'd5;
    run_single("nop");

    clear_inputs();
    iOpcode = 5'd1; iSr1 = 4'd2; iSr2 = 4'd2; iData1 = 16'h1111; iData2 = 16'h0022;
    iWbEn = 1; iWbAddr = 4'd2; iWbData = 16'h5555; iAlutoReg = 1; iWriteBackAddr = 4'd4;
    run_single("sub_wb");
    chk("sub_wb.lit_res", 32'(oResult), 32'd0);
    chk("sub_wb.lit_nvz", 32'(oNVZ), 32'b001);

    clear_inputs();
    iOpcode = 5'd0; iData1 = 16'd3; iData2 = 16'd4; iWbEn = 1; iWbAddr = 4'd0; iWbData = 16'hBEEF;
    iAlutoReg = 1; iWriteBackAddr = 4'd0;
    run_single("tag0");
    chk("tag0.lit_res", 32'(oResult), 32'd7);

    clear_inputs();
    iOpcode = 5'd14; iData1 = 16'd300; iData2 = 16'd300; iWriteBackAddr = 4'd5;
    run_mul("mul300");
    chk("mul300.lit_res", 32'(oResult), 32'h5F90);
    chk("mul300.lit_nvz", 32'(oNVZ), 32'b010);

    clear_inputs();
    iOpcode = 5'd11; iData1 = 16'h0010; iSr2 = 4'd3; iData2 = 16'hAAAA; iWbEn = 1; iWbAddr = 4'd3;
    iWbData = 16'h1234; iALUSrc = 1; iImm = 16'h0004; iMemWrite = 1;
    run_single("store");
    chk("store.lit_res", 32'(oResult), 32'h0014);
    chk("store.lit_sd", 32'(oStoreData), 32'h1234);
    chk("store.lit_nvz", 32'(oNVZ), 32'b010);

    // Abort a multiply in its seventh busy cycle with an asynchronous reset.
    clear_inputs();
    iOpcode = 5'd14; iData1 = 16'd1234; iData2 = 16'd77; iWriteBackAddr = 4'd6;
    tick();
    clear_inputs();
    for (int c = 0; c < 6; c++) tick();
    chk("abort.busy", 32'(oStall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.stall", 32'(oStall), 32'd0);
    chk("abort.res", 32'(oResult), 32'd0);
    chk("abort.ctrl", 32'(out_ctrl()), 32'd0);
    chk("abort.nvz", 32'(oNVZ), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    iOpcode = 5'd0; iData1 = 16'd20; iData2 = 16'd22; iAlutoReg = 1; iWriteBackAddr = 4'd7;
    run_single("post_abort_add");
    chk("post_abort_add.lit", 32'(oResult), 32'd42);

    for (int i = 0; i < 300; i++) begin
      if (i % 30 == 29) begin
        rand_inputs(1);
        iOpcode = 5'd14;
        run_mul("rnd_mul");
      end else begin
        rand_inputs(0);
        run_single("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
